// File: rtl/freq_sel_axi_regs.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : freq_sel_axi_regs
// Desc   : AXI4-Lite register block for the double-banked frequency-selection
//          table (shadow/active banks, synchronous lookup port). Optional macro
//          FREQ_SEL_READBACK_EN enables shadow-bank readback at offset 0x08.
// Rev    : 1.0  initial release
//==============================================================================
module freq_sel_axi_regs #(
   parameter int N_ENTRY   = 32,
   parameter int BIN_WIDTH = 14,
   parameter int CH_WIDTH  = 4
) (
   input  logic                          clk_100MHz,
   input  logic                          reset,
   input  logic [4:0]                    s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [31:0]                   s_axi_wdata,
   input  logic [3:0]                    s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [4:0]                    s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [31:0]                   s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   input  logic [4:0]                    lut_addr,
   output logic [CH_WIDTH+BIN_WIDTH-1:0] lut_data,
   output logic [5:0]                    lut_count,
   output logic                          lut_en
);

   localparam int         c_DW        = CH_WIDTH + BIN_WIDTH;
   localparam int         c_IW        = $clog2(2 * N_ENTRY);
   localparam logic [4:0] c_A_ENTRY   = 5'h00;
   localparam logic [4:0] c_A_COMMIT  = 5'h04;
   localparam logic [4:0] c_A_RDBK    = 5'h08;
   localparam logic [4:0] c_A_STATUS  = 5'h0C;
   localparam logic [4:0] c_A_CONTROL = 5'h10;
   localparam logic [1:0] c_OKAY      = 2'b00;
   localparam logic [1:0] c_SLVERR    = 2'b10;
   localparam logic [5:0] c_N6        = 6'(N_ENTRY);
   localparam logic [c_IW-1:0] c_NI   = c_IW'(N_ENTRY);

   typedef enum logic [1:0] {W_RST = 2'd0, W_IDLE = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_RST = 2'd0, R_IDLE = 2'd1, R_DATA = 2'd2} r_state_t;

   w_state_t r_wstate, w_wstate_nxt;
   r_state_t r_rstate, w_rstate_nxt;

   logic [c_DW-1:0] r_mem [2*N_ENTRY];

   logic            r_aw_got, r_w_got;
   logic [4:0]      r_awaddr;
   logic [31:0]     r_wdata;
   logic [1:0]      r_bresp, r_rresp;
   logic [31:0]     r_rdata;
   logic [5:0]      r_wr_ptr, r_lut_count;
   logic            r_overflow, r_bank, r_lut_en;
   logic [7:0]      r_commit_cnt;
   logic [c_DW-1:0] r_lut_data;

   logic            w_wr_fire, w_rd_fire;
   logic [4:0]      w_wr_addr;
   logic [31:0]     w_wr_data, w_rd_data, w_status;
   logic [1:0]      w_bresp, w_rd_resp;
   logic            w_is_entry, w_entry_ok, w_commit, w_ctrl_wr;
   logic [c_IW-1:0] w_shadow_idx, w_act_idx;
   logic [c_DW-1:0] w_entry;
   logic [5:0]      w_rb_field;
   logic            w_unused_ok;

   assign w_unused_ok = &{1'b0, s_axi_wstrb, w_wr_data};

   // Write channel: AW and W are captured independently; the effect fires once both are held.
   always_comb begin : p_wr_fsm
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      w_wr_fire     = 1'b0;
      w_wstate_nxt  = r_wstate;
      case (r_wstate)
         W_RST:  w_wstate_nxt = W_IDLE;
         W_IDLE: begin
            s_axi_awready = ~r_aw_got;
            s_axi_wready  = ~r_w_got;
            w_wr_fire     = (r_aw_got | s_axi_awvalid) & (r_w_got | s_axi_wvalid);
            if (w_wr_fire) w_wstate_nxt = W_RESP;
         end
         W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_RST;
      endcase
   end

   always_comb begin : p_wr_decode
      w_wr_addr  = r_aw_got ? r_awaddr : s_axi_awaddr;
      w_wr_data  = r_w_got  ? r_wdata  : s_axi_wdata;
      w_is_entry = w_wr_fire && (w_wr_addr == c_A_ENTRY);
      w_entry_ok = w_is_entry && (r_wr_ptr != c_N6);
      w_commit   = w_wr_fire && (w_wr_addr == c_A_COMMIT) && w_wr_data[0];
      w_ctrl_wr  = w_wr_fire && (w_wr_addr == c_A_CONTROL);
      w_entry    = {w_wr_data[16 +: CH_WIDTH], w_wr_data[0 +: BIN_WIDTH]};
      case (w_wr_addr)
         c_A_ENTRY:                                 w_bresp = (r_wr_ptr == c_N6) ? c_SLVERR : c_OKAY;
         c_A_COMMIT, c_A_RDBK, c_A_STATUS, c_A_CONTROL: w_bresp = c_OKAY;
         default:                                   w_bresp = c_SLVERR;
      endcase
   end

   // Shadow bank is the one not selected by r_bank.
   assign w_shadow_idx = (r_bank ? '0 : c_NI) + c_IW'(r_wr_ptr);
   assign w_act_idx    = (r_bank ? c_NI : '0) + c_IW'(lut_addr);

`ifdef FREQ_SEL_READBACK_EN
   logic [5:0]      r_rb_ptr;
   logic [c_IW-1:0] w_rb_idx;
   logic [c_DW-1:0] w_rb_entry;
   assign w_rb_idx   = (r_bank ? '0 : c_NI) + c_IW'(r_rb_ptr);
   assign w_rb_entry = r_mem[w_rb_idx];
   assign w_rb_field = r_rb_ptr;
`else
   assign w_rb_field = 6'd0;
`endif

   assign w_status = {r_commit_cnt, w_rb_field, r_overflow, r_bank, 2'b00,
                      r_lut_count, 2'b00, r_wr_ptr};

   always_comb begin : p_rd_fsm
      s_axi_arready = 1'b0;
      w_rd_fire     = 1'b0;
      w_rstate_nxt  = r_rstate;
      case (r_rstate)
         R_RST:  w_rstate_nxt = R_IDLE;
         R_IDLE: begin
            s_axi_arready = 1'b1;
            w_rd_fire     = s_axi_arvalid;
            if (s_axi_arvalid) w_rstate_nxt = R_DATA;
         end
         R_DATA: if (s_axi_rready) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_RST;
      endcase
   end

   always_comb begin : p_rd_decode
      w_rd_data = 32'd0;
      w_rd_resp = c_OKAY;
      case (s_axi_araddr)
         c_A_ENTRY, c_A_COMMIT: w_rd_data = 32'd0;
`ifdef FREQ_SEL_READBACK_EN
         c_A_RDBK:    w_rd_data = {{(16-CH_WIDTH){1'b0}}, w_rb_entry[c_DW-1 -: CH_WIDTH],
                                   {(16-BIN_WIDTH){1'b0}}, w_rb_entry[BIN_WIDTH-1:0]};
`else
         c_A_RDBK:    w_rd_data = 32'd0;
`endif
         c_A_STATUS:  w_rd_data = w_status;
         c_A_CONTROL: w_rd_data = {30'd0, r_lut_en, 1'b0};
         default:     w_rd_resp = c_SLVERR;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin : p_mem
      if (w_entry_ok) r_mem[w_shadow_idx] <= w_entry;
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin : p_regs
      if (reset) begin
         r_wstate     <= W_RST;
         r_rstate     <= R_RST;
         r_aw_got     <= 1'b0;
         r_w_got      <= 1'b0;
         r_awaddr     <= '0;
         r_wdata      <= '0;
         r_bresp      <= c_OKAY;
         r_rresp      <= c_OKAY;
         r_rdata      <= '0;
         r_wr_ptr     <= '0;
         r_lut_count  <= '0;
         r_overflow   <= 1'b0;
         r_bank       <= 1'b0;
         r_lut_en     <= 1'b0;
         r_commit_cnt <= '0;
         r_lut_data   <= '0;
`ifdef FREQ_SEL_READBACK_EN
         r_rb_ptr     <= '0;
`endif
      end else begin
         r_wstate   <= w_wstate_nxt;
         r_rstate   <= w_rstate_nxt;
         r_lut_data <= r_mem[w_act_idx];
         if (r_wstate == W_IDLE) begin
            if (w_wr_fire) begin
               r_aw_got <= 1'b0;
               r_w_got  <= 1'b0;
               r_bresp  <= w_bresp;
            end else begin
               if (s_axi_awvalid && s_axi_awready) begin
                  r_aw_got <= 1'b1;
                  r_awaddr <= s_axi_awaddr;
               end
               if (s_axi_wvalid && s_axi_wready) begin
                  r_w_got <= 1'b1;
                  r_wdata <= s_axi_wdata;
               end
            end
         end
         if (w_rd_fire) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
         end
`ifdef FREQ_SEL_READBACK_EN
         if (w_rd_fire && (s_axi_araddr == c_A_RDBK))
            r_rb_ptr <= (r_rb_ptr == c_N6 - 6'd1) ? '0 : r_rb_ptr + 6'd1;
`endif
         if (w_entry_ok) r_wr_ptr <= r_wr_ptr + 6'd1;
         if (w_is_entry && !w_entry_ok) r_overflow <= 1'b1;
         // Commit/clear are ordered last so they win over a same-cycle pointer bump.
         if (w_commit) begin
            r_bank       <= ~r_bank;
            r_lut_count  <= r_wr_ptr;
            r_wr_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_commit_cnt <= r_commit_cnt + 8'd1;
`ifdef FREQ_SEL_READBACK_EN
            r_rb_ptr     <= '0;
`endif
         end
         if (w_ctrl_wr) begin
            r_lut_en <= w_wr_data[1];
            if (w_wr_data[0]) begin
               r_wr_ptr   <= '0;
               r_overflow <= 1'b0;
`ifdef FREQ_SEL_READBACK_EN
               r_rb_ptr   <= '0;
`endif
            end
         end
      end
   end

   assign s_axi_bvalid = (r_wstate == W_RESP);
   assign s_axi_bresp  = r_bresp;
   assign s_axi_rvalid = (r_rstate == R_DATA);
   assign s_axi_rdata  = r_rdata;
   assign s_axi_rresp  = r_rresp;
   assign lut_data     = r_lut_data;
   assign lut_count    = r_lut_count;
   assign lut_en       = r_lut_en;

endmodule
`default_nettype wire

// File: doc/freq_sel_axi_regs.md
# freq_sel_axi_regs

AXI4-Lite responder (slave) holding the frequency-selection table of the frequency selector. Software pushes tone entries into a shadow bank, commits them atomically into the active bank, and reads status; the channelizer datapath reads the active bank through a synchronous lookup port. It is the register-side endpoint that the AXI master (VIP in simulation, PS in hardware) talks to at offsets 0x00–0x10.

## Interface
- N_ENTRY, 32, table depth per bank (max 63)
- BIN_WIDTH, 14, frequency-bin field width
- CH_WIDTH, 4, channel-index field width
- clk_100MHz  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- s_axi_awaddr / awvalid / awready  in/in/out  5/1/1  write address channel
- s_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel (wstrb ignored, full-word writes)
- s_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response
- s_axi_araddr / arvalid / arready  in/in/out  5/1/1  read address
- s_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data
- lut_addr  in  5  active-bank entry index
- lut_data  out  18  {ch[3:0], bin[13:0]} of active entry, 1-cycle latency
- lut_count  out  6  number of valid entries in active bank
- lut_en  out  1  datapath enable (CONTROL bit1)

## Operation
- Register map (word offsets): 0x00 ENTRY (W), 0x04 COMMIT (W), 0x08 READBACK (R, see Configuration), 0x0C STATUS (R), 0x10 CONTROL (R/W). Other addresses: write ignored with SLVERR (2'b10), read returns 0 with SLVERR.
- ENTRY write: shadow[wr_ptr] <= {wdata[19:16], wdata[13:0]}; wr_ptr++. If wr_ptr == N_ENTRY: data dropped, overflow <= 1, BRESP SLVERR. Otherwise OKAY.
- COMMIT write with wdata[0]=1: swap bank select, lut_count <= wr_ptr, wr_ptr <= 0, overflow <= 0, commit_cnt++ (8-bit, wraps 255->0). wdata[0]=0: no effect, OKAY. Commit with wr_ptr=0 is legal (lut_count=0). New shadow bank holds stale data; software rewrites all entries before next commit.
- STATUS read: [5:0] wr_ptr, [13:8] lut_count, [16] active bank, [17] overflow, [31:24] commit_cnt, others 0.
- CONTROL write: bit0=1 clears wr_ptr and overflow (self-clearing, reads 0); bit1 stored -> lut_en. Write 1 => clear only, lut_en <= 0; write 2 => lut_en <= 1. Read returns {30'b0, lut_en, 1'b0}.
- Write FSM: W_IDLE (awready=wready=1 until each captured; AW and W accepted in either order or same cycle) -> W_RESP (bvalid=1 until bready). Channel already captured drops its ready until response done.
- Read FSM: R_IDLE (arready=1) -> R_DATA (rvalid=1, rdata held stable until rready).
- Read and write FSMs independent; both may complete in the same cycle.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp/rdata 0, lut_data 0, lut_count 0, lut_en 0, wr_ptr 0, bank 0, commit_cnt 0. Table RAM contents not reset. Readies rise on first clock edge after reset release.
- Write: last of AW/W handshakes at cycle N -> register effect and bvalid at N+1. Back-to-back: next AW/W accepted the cycle after B handshake.
- Read: AR handshake at N -> rvalid, rdata at N+1; rdata samples state at cycle N (a same-cycle write effect is not visible).
- Lookup: lut_data at N+1 reflects active[lut_addr sampled at N]; after COMMIT effect at cycle M, lookups sampled at M and later use the new bank. lut_addr >= lut_count returns stale RAM data; consumer gates with lut_count.
- Reset asserted mid-transaction: FSMs return to idle, pending response discarded, no partial register update.

## Configuration
- FREQ_SEL_READBACK_EN defined: READBACK (0x08) read returns {12'b0, shadow[rb_ptr]} in [19:16]/[13:0] layout, OKAY, rb_ptr increments per read (wraps at N_ENTRY); rb_ptr reset by COMMIT, CONTROL clear, reset. STATUS[23:18] shows rb_ptr.
- Not defined: 0x08 reads 0 with OKAY, no rb_ptr logic, STATUS[23:18]=0.

## Test plan
- 32 ENTRY writes data {i[3:0],2'b0,i[13:0]}, i=0..31, then COMMIT=1 -> all BRESP OKAY; STATUS=0x0101_2000 (lut_count 32, bank 1, cnt 1); lut_addr=5 gives lut_data=0x14005 next cycle.
- 33rd ENTRY write before commit -> BRESP SLVERR, STATUS[17]=1, wr_ptr stays 32; COMMIT clears overflow.
- CONTROL=1 after 10 ENTRY writes -> STATUS[5:0]=0, lut_en=0; CONTROL=2 -> lut_en=1, CONTROL reads 0x2.
- AW then W 3 cycles apart, bready held low 5 cycles -> bvalid held, no second AW accepted until B handshake; same-cycle STATUS read returns pre-write wr_ptr.
- Read 0x14 -> rdata 0, rresp SLVERR; reset asserted while bvalid=1 -> bvalid 0 immediately, lut_count 0.
- FREQ_SEL_READBACK_EN: write 3 entries, read 0x08 three times -> entries 0,1,2 in order; without macro -> 0, OKAY.
